// File: rtl/mul_accumulate_stage.sv
// mul_accumulate_stage: sums len unsigned 64-bit products (valid/ready in) into an ACC_W-bit accumulator with sticky carry, result via valid/ready out
module mul_accumulate_stage #(
  parameter int ACC_W = 72,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [63:0]      in_prod,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic             out_ovf,
  output logic             busy
);
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
  state_t state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic ovf_q, ovf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ACC_W:0] sum;
  assign sum = {1'b0, acc_q} + (ACC_W+1)'(in_prod);
  always_comb begin
    state_d = state_q;
    acc_d = acc_q;
    ovf_d = ovf_q;
    cnt_d = cnt_q;
    case (state_q)
      IDLE: if (start) begin
        acc_d = '0;
        ovf_d = 1'b0;
        cnt_d = len;
        state_d = len != '0 ? ACCUM : DONE;
      end
      ACCUM: if (in_valid) begin
        acc_d = sum[ACC_W-1:0];
        ovf_d = ovf_q | sum[ACC_W];
        cnt_d = cnt_q - CNT_W'(1);
        state_d = cnt_q == CNT_W'(1) ? DONE : ACCUM;
      end
      DONE: state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q <= '0;
      ovf_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q <= acc_d;
      ovf_q <= ovf_d;
      cnt_q <= cnt_d;
    end
  end
  assign in_ready = state_q == ACCUM;
  assign out_valid = state_q == DONE;
  assign busy = state_q != IDLE;
  assign out_acc = acc_q;
  assign out_ovf = ovf_q;
endmodule

// File: tb/tb_mul_accumulate_stage.sv
// tb_mul_accumulate_stage: random and directed jobs on 72- and 64-bit accumulator instances checked against an exact 128-bit sum model
module tb_mul_accumulate_stage;
  logic clk = 1'b0;
  logic rst, start, in_valid, out_ready;
  logic [7:0] len;
  logic [63:0] in_prod;
  logic ir72, ov72, of72, bz72, ir64, ov64, of64, bz64;
  logic [71:0] acc72;
  logic [63:0] acc64;
  int n = 0;
  int fails = 0;
  logic [63:0] prods[$];
  logic [127:0] tot;
  always #5 clk = ~clk;
  mul_accumulate_stage #(.ACC_W(72), .CNT_W(8)) u72 (
    .clk(clk), .rst(rst), .start(start), .len(len), .in_valid(in_valid), .in_ready(ir72),
    .in_prod(in_prod), .out_valid(ov72), .out_ready(out_ready), .out_acc(acc72), .out_ovf(of72), .busy(bz72)
  );
  mul_accumulate_stage #(.ACC_W(64), .CNT_W(8)) u64 (
    .clk(clk), .rst(rst), .start(start), .len(len), .in_valid(in_valid), .in_ready(ir64),
    .in_prod(in_prod), .out_valid(ov64), .out_ready(out_ready), .out_acc(acc64), .out_ovf(of64), .busy(bz64)
  );
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic chk_result(input string tag);
    chk({tag, "_valid72"}, 128'(ov72), 128'(1));
    chk({tag, "_valid64"}, 128'(ov64), 128'(1));
    chk({tag, "_acc72"}, 128'(acc72), 128'(tot[71:0]));
    chk({tag, "_acc64"}, 128'(acc64), 128'(tot[63:0]));
    chk({tag, "_ovf72"}, 128'(of72), 128'(tot[127:72] != 0));
    chk({tag, "_ovf64"}, 128'(of64), 128'(tot[127:64] != 0));
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_ready"}, 128'({ir72, ir64}), 128'(0));
    chk({tag, "_valid"}, 128'({ov72, ov64}), 128'(0));
    chk({tag, "_acc72"}, 128'(acc72), 128'(0));
    chk({tag, "_acc64"}, 128'(acc64), 128'(0));
    chk({tag, "_ovf"}, 128'({of72, of64}), 128'(0));
    chk({tag, "_busy"}, 128'({bz72, bz64}), 128'(0));
  endtask
  // gap<0 means random 0..2 idle cycles before each beat; abort_at/spur_at<0 disable those events
  task automatic job(input string tag, input int gap, input int hold, input int abort_at, input int spur_at);
    int l = prods.size();
    tot = '0;
    start = 1'b1;
    len = 8'(l);
    step();
    start = 1'b0;
    if (l == 0) begin
      in_valid = 1'b1;
      in_prod = 64'hdead;
    end
    for (int i = 0; i < l; i++) begin
      if (i == abort_at) begin
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_zero({tag, "_abort"});
        return;
      end
      for (int g = 0; g < (gap < 0 ? int'($urandom_range(0, 2)) : gap); g++) begin
        chk({tag, "_bubble_ready"}, 128'({ir72, ir64}), 128'(3));
        step();
      end
      in_valid = 1'b1;
      in_prod = prods[i];
      if (i == spur_at) begin
        start = 1'b1;
        len = 8'd9;
      end
      chk({tag, "_beat_ready"}, 128'({ir72, ir64}), 128'(3));
      chk({tag, "_pre_valid"}, 128'({ov72, ov64}), 128'(0));
      step();
      start = 1'b0;
      in_valid = 1'b0;
      tot = tot + 128'(prods[i]);
    end
    chk_result(tag);
    chk({tag, "_done_ready"}, 128'({ir72, ir64}), 128'(0));
    for (int h = 0; h < hold; h++) begin
      step();
      chk({tag, "_hold_acc72"}, 128'(acc72), 128'(tot[71:0]));
      chk({tag, "_hold_valid"}, 128'({ov72, ov64}), 128'(3));
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    in_valid = 1'b0;
    chk({tag, "_idle_busy"}, 128'({bz72, bz64}), 128'(0));
    chk({tag, "_idle_valid"}, 128'({ov72, ov64}), 128'(0));
    chk({tag, "_idle_acc64"}, 128'(acc64), 128'(tot[63:0]));
  endtask
  initial begin
    rst = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0; in_prod = '0; out_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    chk_zero("reset");
    in_valid = 1'b1;
    in_prod = 64'd99;
    step();
    in_valid = 1'b0;
    chk_zero("idle_in_valid");
    prods = '{64'd6, 64'd12, 64'd20};
    job("basic", 0, 0, -1, -1);
    chk("basic_lit", 128'(acc72), 128'(38));
    prods = '{64'h1_0000_0000, 64'd5};
    job("bubbles", 3, 5, -1, -1);
    chk("bubbles_lit", 128'(acc72), 128'h1_0000_0005);
    prods.delete();
    job("zero_len", 0, 2, -1, -1);
    prods = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};
    job("overflow", 0, 1, -1, -1);
    chk("overflow_lit", 128'({of64, acc64}), {63'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE});
    prods = '{64'd1};
    job("after_ovf", 0, 0, -1, -1);
    prods = '{{$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}};
    job("ign_start", -1, 1, -1, 2);
    job("reset_mid", -1, 0, 2, -1);
    prods = '{64'd7};
    job("post_reset", 0, 0, -1, -1);
    for (int j = 0; j < 6; j++) begin
      prods.delete();
      repeat ($urandom_range(1, 8)) prods.push_back({$urandom, $urandom});
      job("random", -1, int'($urandom_range(0, 3)), -1, -1);
    end
    prods.delete();
    repeat (255) prods.push_back(64'hFFFF_FFFF_FFFF_FFFF);
    job("max_len", 0, 0, -1, -1);
    chk("max_len_lit", 128'({of72, acc72}), 128'(73'h0_FE_FFFF_FFFF_FFFF_FF01));
    $display("End of test - %0d assertions evaluated, %0d failures", n, fails);
    $finish;
  end
endmodule

// File: doc/mul_accumulate_stage.md
Name: mul_accumulate_stage

Overview:
- Sequential stage directly downstream of the 32x32 Wallace multiplier.
- Consumes the multiplier's 64-bit unsigned products over a valid/ready handshake and sums a programmed number of them into a wide accumulator.
- Presents the final sum with a valid/ready output handshake.
- Used for dot-product and MAC loops: the multiplier stays combinational, and this block supplies the registered state.

Parameters:
- ACC_W, 72, accumulator/result width in bits; must be >= 64.
- CNT_W, 8, width of the beat-count field; a job is up to 2^CNT_W-1 products.

Ports:
- clk  input  1  single clock, all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a new job; honoured only in IDLE.
- len  input  CNT_W  number of products in the job, sampled with start.
- in_valid  input  1  in_prod is valid.
- in_ready  output  1  block accepts a product this cycle.
- in_prod  input  64  unsigned product from the multiplier.
- out_valid  output  1  out_acc/out_ovf are valid.
- out_ready  input  1  consumer accepts the result.
- out_acc  output  ACC_W  accumulated sum, modulo 2^ACC_W.
- out_ovf  output  1  sticky: a carry left bit ACC_W-1 at some point during the job.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Interface: one clock (clk); reset (rst) is synchronous and active-high.
- Reset (rst=1 at a rising edge, wins over everything, including mid-job): state=IDLE, acc=0, ovf=0, cnt=0; in_ready=0, out_valid=0, out_acc=0, out_ovf=0, busy=0. Any partial job is discarded.
- FSM has three states: IDLE, ACCUM, DONE.
- IDLE:
  - in_ready=0, out_valid=0.
  - start=1 clears acc and ovf and loads cnt=len.
  - Next state is ACCUM if len!=0, DONE if len==0.
  - in_valid in IDLE is ignored.
- ACCUM:
  - in_ready=1.
  - A beat is in_valid & in_ready.
  - On a beat: acc <= acc + zero_extend(in_prod); ovf <= ovf | carry_out; cnt <= cnt-1.
  - Idle cycles (in_valid=0) leave all state unchanged.
  - The beat with cnt==1 is the last; next state is DONE.
- DONE:
  - in_ready=0, out_valid=1.
  - out_acc=acc and out_ovf=ovf, both held stable while out_ready=0.
  - out_valid & out_ready moves to IDLE the next cycle, with out_valid=0.
- Latency: out_valid rises on the cycle after the last accepted beat, or the cycle after start when len=0.
- A new start is accepted at the earliest in the cycle after the output handshake; there is no overlap of jobs.
- start while busy=1 is ignored; len is not re-sampled.
- out_acc holds its last value in IDLE, and reads 0 after reset.
- Arithmetic:
  - Unsigned throughout.
  - The add is ACC_W+1 bits; bit ACC_W is the carry_out.
  - acc wraps modulo 2^ACC_W.
  - With ACC_W=72, overflow is impossible for 255 beats; with ACC_W=64 it is reachable.
- All outputs are driven from registers or state decode only; there is no combinational path from in_prod to out_acc.

Test Plan:
- Basic sum: start, len=3, products 6,12,20 as back-to-back beats -> out_valid rises 1 cycle after the 3rd beat; out_acc=38, out_ovf=0; with out_ready=1, busy drops the next cycle.
- Bubbles and backpressure: len=2, products 0x1_0000_0000 and 5 with 3 idle cycles between them; out_ready held 0 for 5 cycles -> in_ready=1 throughout ACCUM; out_acc=0x1_0000_0005 stable all 5 cycles; IDLE on the cycle after out_ready=1.
- Zero length: start with len=0 -> out_valid=1 the next cycle, out_acc=0, out_ovf=0; in_valid pulses during the job are not accepted (in_ready=0).
- Overflow (ACC_W=64): len=2, both products 0xFFFF_FFFF_FFFF_FFFF -> out_acc=0xFFFF_FFFF_FFFF_FFFE, out_ovf=1; the next job with len=1 and product 1 -> out_acc=1, out_ovf=0.
- Ignored start and mid-job reset: len=4; after 2 beats assert start with len=9 -> ignored, job still finishes after 2 more beats. Repeat the job, asserting rst after 2 beats -> next cycle all outputs 0, state IDLE; a fresh len=1, product 7 job -> out_acc=7.
- Max length (ACC_W=72): len=255, every product 0xFFFF_FFFF_FFFF_FFFF -> out_acc=255*(2^64-1)=0xFE_FFFF_FFFF_FFFF_FF01, out_ovf=0.
